// File: rtl/contador_sincrono_updown_param_pkg.sv
// contador_sincrono_updown_param_pkg: shared direction/mode constants and parameter legality check
package contador_sincrono_updown_param_pkg;
   localparam logic SOBE  = 1'b1;
   localparam logic DESCE = 1'b0;
   localparam int MODO_WRAP   = 0;
   localparam int MODO_SATURA = 1;
   function automatic bit parametros_validos(input int width, input int modulo, input int satura);
      return width >= 2 && width <= 16 && modulo >= 2 && modulo <= (1 << width) &&
             (satura == MODO_WRAP || satura == MODO_SATURA);
   endfunction
endpackage

// File: rtl/contador_proximo_estado.sv
// contador_proximo_estado: combinational next count, terminal count and next ovf
module contador_proximo_estado
   import contador_sincrono_updown_param_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int MODULO = 16,
   parameter int SATURA = MODO_WRAP
) (
   input  logic [WIDTH-1:0] q,
   input  logic             T,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q_next,
   output logic             tc,
   output logic             ovf_next
);
   localparam logic [WIDTH-1:0] LIMITE = WIDTH'(MODULO - 1);
   logic             d_ok;
   logic [WIDTH-1:0] volta;
   // load beats count beats hold; a limit hit either wraps or holds depending on SATURA
   always_comb begin
      tc       = T & (((up == SOBE) & (q == LIMITE)) | ((up == DESCE) & (q == '0)));
      d_ok     = {1'b0, d} < (WIDTH + 1)'(MODULO);
      volta    = (SATURA == MODO_SATURA) ? q : ((up == SOBE) ? '0 : LIMITE);
      q_next   = load ? (d_ok ? d : LIMITE) :
                 !T   ? q :
                 tc   ? volta :
                 (up == SOBE) ? q + WIDTH'(1) : q - WIDTH'(1);
      ovf_next = ~load & tc;
   end
endmodule

// File: rtl/contador_sincrono_updown_param.sv
// contador_sincrono_updown_param: cascadable modulo-N up/down counter with load, wrap or saturate
module contador_sincrono_updown_param
   import contador_sincrono_updown_param_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int MODULO = 16,
   parameter int SATURA = MODO_WRAP
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             T,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf
);
   logic [WIDTH-1:0] q_next;
   logic             ovf_next;

   if (!parametros_validos(WIDTH, MODULO, SATURA)) begin : g_param_invalido
      $error("contador_sincrono_updown_param: illegal WIDTH/MODULO/SATURA combination");
   end

   contador_proximo_estado #(
      .WIDTH (WIDTH),
      .MODULO(MODULO),
      .SATURA(SATURA)
   ) u_prox (
      .q       (q),
      .T       (T),
      .up      (up),
      .load    (load),
      .d       (d),
      .q_next  (q_next),
      .tc      (tc),
      .ovf_next(ovf_next)
   );

   // count and event registers; clear_n drops them to zero at once, abandoning any pending ovf
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         q   <= '0;
         ovf <= 1'b0;
      end else begin
         q   <= q_next;
         ovf <= ovf_next;
      end
   end
endmodule

// File: tb/tb_contador_sincrono_updown_param.sv
// tb_contador_sincrono_updown_param: directed and random checks of three counter variants plus a cascade
module tb_contador_sincrono_updown_param;
   logic       clk = 1'b0, clear_n = 1'b1, t = 1'b0, up = 1'b0, load = 1'b0, ct = 1'b0;
   logic [3:0] d = '0;
   logic [3:0] qa [3];
   logic       tca [3], ovfa [3];
   logic [3:0] qlo, qhi, zero4 = '0;
   logic       tclo, tchi, ovflo, ovfhi, um = 1'b1, zero = 1'b0;
   int         checks = 0, errors = 0;
   int         mq [3] = '{0, 0, 0};
   bit         mo [3] = '{0, 0, 0};
   int         mm [3] = '{16, 10, 10};
   bit         ms [3] = '{0, 0, 1};
   int         cnt = 0;

   always #5 clk = ~clk;

   contador_sincrono_updown_param #(.WIDTH(4), .MODULO(16), .SATURA(0)) u0 (
      .clk(clk), .clear_n(clear_n), .T(t), .up(up), .load(load), .d(d), .q(qa[0]), .tc(tca[0]), .ovf(ovfa[0]));
   contador_sincrono_updown_param #(.WIDTH(4), .MODULO(10), .SATURA(0)) u1 (
      .clk(clk), .clear_n(clear_n), .T(t), .up(up), .load(load), .d(d), .q(qa[1]), .tc(tca[1]), .ovf(ovfa[1]));
   contador_sincrono_updown_param #(.WIDTH(4), .MODULO(10), .SATURA(1)) u2 (
      .clk(clk), .clear_n(clear_n), .T(t), .up(up), .load(load), .d(d), .q(qa[2]), .tc(tca[2]), .ovf(ovfa[2]));
   contador_sincrono_updown_param #(.WIDTH(4), .MODULO(10), .SATURA(0)) u_lo (
      .clk(clk), .clear_n(clear_n), .T(ct), .up(um), .load(zero), .d(zero4), .q(qlo), .tc(tclo), .ovf(ovflo));
   contador_sincrono_updown_param #(.WIDTH(4), .MODULO(10), .SATURA(0)) u_hi (
      .clk(clk), .clear_n(clear_n), .T(tclo), .up(um), .load(zero), .d(zero4), .q(qhi), .tc(tchi), .ovf(ovfhi));

   function automatic int nxt(input int q, input int m, input bit s, input bit tt, input bit uu,
                              input bit ll, input int dv, output bit ov);
      int n;
      ov = 1'b0;
      if (ll) return (dv < m) ? dv : m - 1;
      if (!tt) return q;
      n = uu ? q + 1 : q - 1;
      if (n < 0 || n >= m) begin
         ov = 1'b1;
         n = s ? q : (n + m) % m;
      end
      return n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input bit tt, input bit uu, input bit ll, input int dd);
      bit ov;
      @(negedge clk);
      t = tt; up = uu; load = ll; d = 4'(dd); ct = tt;
      #1;
      for (int i = 0; i < 3; i++)
         chk($sformatf("tc%0d q=%0d", i, mq[i]), 32'(tca[i]), 32'(tt && (uu ? mq[i] == mm[i] - 1 : mq[i] == 0)));
      chk("tc_lo", 32'(tclo), 32'(tt && cnt % 10 == 9));
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         mq[i] = nxt(mq[i], mm[i], ms[i], tt, uu, ll, dd & 15, ov);
         mo[i] = ov;
      end
      if (tt) cnt = (cnt + 1) % 100;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("q%0d", i), 32'(qa[i]), 32'(mq[i]));
         chk($sformatf("ovf%0d", i), 32'(ovfa[i]), 32'(mo[i]));
      end
      chk("cascade", 32'({qhi, qlo}), 32'({4'(cnt / 10), 4'(cnt % 10)}));
   endtask

   task automatic rst_pulse();
      #2;
      clear_n = 1'b0;
      t = 1'b0; load = 1'b0; ct = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_q%0d", i), 32'(qa[i]), 32'd0);
         chk($sformatf("rst_ovf%0d", i), 32'(ovfa[i]), 32'd0);
         mq[i] = 0;
         mo[i] = 1'b0;
      end
      chk("rst_cascade", 32'({qhi, qlo}), 32'd0);
      cnt = 0;
      @(negedge clk);
      clear_n = 1'b1;
   endtask

   initial begin
      // asynchronous reset with load/T active across an edge: ignored, tc tracks q=0 going down
      #2;
      clear_n = 1'b0;
      t = 1'b1; up = 1'b0; load = 1'b1; d = 4'd5;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("reset_q%0d", i), 32'(qa[i]), 32'd0);
         chk($sformatf("reset_ovf%0d", i), 32'(ovfa[i]), 32'd0);
         chk($sformatf("reset_tc%0d", i), 32'(tca[i]), 32'd1);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) chk($sformatf("reset_hold_q%0d", i), 32'(qa[i]), 32'd0);
      @(negedge clk);
      t = 1'b0; load = 1'b0;
      clear_n = 1'b1;
      // up count 0..15,0 on the modulo-16 counter
      for (int i = 0; i < 17; i++) cyc(1, 1, 0, 0);
      // loads: 4 accepted everywhere, 13 clamped to 9 on modulo-10 counters
      cyc(1, 1, 1, 4);
      cyc(1, 1, 1, 13);
      // hold with T=0
      for (int i = 0; i < 3; i++) cyc(0, $urandom_range(0, 1), 0, 0);
      // down count from 0 wraps to MODULO-1
      rst_pulse();
      for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0);
      // saturating limit held from 7 upward, direction flip takes effect immediately
      cyc(1, 1, 1, 7);
      for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
      cyc(1, 0, 0, 0);
      // reset between edges mid-count at q=6, counting resumes from 0
      cyc(1, 1, 1, 5);
      cyc(1, 1, 0, 0);
      rst_pulse();
      cyc(1, 1, 0, 0);
      // cascade full cycle 00..99,00
      rst_pulse();
      for (int i = 0; i < 100; i++) cyc(1, 1, 0, 0);
      // random traffic with occasional resets
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 59) == 0) rst_pulse();
         cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
             int'($urandom_range(0, 15)));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
